// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO storage stage: status-FSM encoding and depth derivation.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_NORMAL = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  function automatic int unsigned depth_of(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Register-array storage for the FIFO: synchronous write port, synchronous (registered) read port, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned width     = 7,
  parameter int unsigned addr_bits = 3
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [addr_bits-1:0] i_waddr,
  input  logic [width:0]       i_wdata,
  input  logic                 i_re,
  input  logic [addr_bits-1:0] i_raddr,
  output logic [width:0]       o_rdata
);

  localparam int unsigned DEPTH = depth_of(addr_bits);

  logic [width:0] r_mem [DEPTH];
  logic [width:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register only advances on an accepted read, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_store.sv
// FIFO storage/control stage: EMPTY/NORMAL/FULL status FSM, circular pointers, occupancy count,
// registered read data with one-cycle valid pulse, and sticky overflow/underflow flags.
module fifo_store
  import fifo_pkg::*;
#(
  parameter int unsigned width     = 7,
  parameter int unsigned addr_bits = 3
) (
  input  logic                 clk,
  input  logic                 Clear,
  input  logic                 wr_req,
  input  logic [width:0]       data_in,
  input  logic                 rd_req,
  output logic [width:0]       data_out,
  output logic                 data_valid,
  output logic                 full,
  output logic                 empty,
  output logic [addr_bits:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned DEPTH = depth_of(addr_bits);
  localparam int unsigned AW    = addr_bits;
  localparam int unsigned CW    = addr_bits + 1;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_nxt;
  logic           r_full;
  logic           r_empty;
  logic           r_valid;
  logic           r_overflow;
  logic           r_underflow;
  logic           r_loaded;
  logic           w_wr_ok;
  logic           w_rd_ok;
  logic [width:0] w_rd_q;

  assign w_wr_ok = wr_req && (r_state != ST_FULL);
  assign w_rd_ok = rd_req && (r_state != ST_EMPTY);

  fifo_ram #(
    .width     (width),
    .addr_bits (addr_bits)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_re    (w_rd_ok),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_q)
  );

  // Next-state and next-count logic for the status FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      ST_EMPTY: begin
        if (w_wr_ok) begin
          w_state_nxt = ST_NORMAL;
          w_count_nxt = r_count + CW'(1);
        end
      end
      ST_NORMAL: begin
        if (w_wr_ok && !w_rd_ok) begin
          w_count_nxt = r_count + CW'(1);
          if (r_count == CW'(DEPTH - 1)) begin
            w_state_nxt = ST_FULL;
          end
        end else if (w_rd_ok && !w_wr_ok) begin
          w_count_nxt = r_count - CW'(1);
          if (r_count == CW'(1)) begin
            w_state_nxt = ST_EMPTY;
          end
        end
      end
      ST_FULL: begin
        if (w_rd_ok) begin
          w_state_nxt = ST_NORMAL;
          w_count_nxt = r_count - CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      r_state     <= ST_EMPTY;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_valid     <= 1'b0;
      r_loaded    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_state_nxt == ST_FULL);
      r_empty  <= (w_state_nxt == ST_EMPTY);
      r_valid  <= w_rd_ok;
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_loaded <= 1'b1;
      end
      if (wr_req && (r_state == ST_FULL)) begin
        r_overflow <= 1'b1;
      end
      if (rd_req && (r_state == ST_EMPTY)) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // The RAM read register has no reset; mask it until a read lands after Clear.
  assign data_out   = r_loaded ? w_rd_q : '0;
  assign data_valid = r_valid;
  assign full       = r_full;
  assign empty      = r_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_fifo_store.sv
// Directed self-checking bench for fifo_store (width=7, addr_bits=3, depth 8).
module tb_fifo_store;

  logic       clk = 1'b0;
  logic       Clear;
  logic       wr_req;
  logic [7:0] data_in;
  logic       rd_req;
  logic [7:0] data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  fifo_store #(.width(7), .addr_bits(3)) dut (
    .clk        (clk),
    .Clear      (Clear),
    .wr_req     (wr_req),
    .data_in    (data_in),
    .rd_req     (rd_req),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r);
    @(negedge clk);
    wr_req  = w;
    data_in = d;
    rd_req  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"},  32'(data_out),   32'h0);
    chk({tag, "_valid"}, 32'(data_valid), 32'h0);
    chk({tag, "_count"}, 32'(count),      32'h0);
    chk({tag, "_empty"}, 32'(empty),      32'h1);
    chk({tag, "_full"},  32'(full),       32'h0);
    chk({tag, "_ovf"},   32'(overflow),   32'h0);
    chk({tag, "_unf"},   32'(underflow),  32'h0);
  endtask

  logic [7:0] exp_sim [10];

  initial begin
    // Reset with random inputs applied
    Clear   = 1'b0;
    wr_req  = 1'($urandom_range(0, 1));
    rd_req  = 1'($urandom_range(0, 1));
    data_in = 8'($urandom_range(0, 255));
    #22;
    chk_reset_outputs("reset");
    @(negedge clk);
    Clear  = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_empty", 32'(empty), 32'h0);
      chk("fill_full",  32'(full),  (i == 8) ? 32'h1 : 32'h0);
    end

    // Overflow at full
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_flag",  32'(overflow), 32'h1);
    chk("ovf_count", 32'(count),    32'h8);
    chk("ovf_full",  32'(full),     32'h1);
    chk("ovf_unf",   32'(underflow), 32'h0);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_valid", 32'(data_valid), 32'h1);
      chk("drain_data",  32'(data_out),   32'(i));
      chk("drain_count", 32'(count),      32'(8 - i));
      chk("drain_full",  32'(full),       32'h0);
    end
    chk("drain_empty", 32'(empty), 32'h1);
    step(1'b0, 8'h00, 1'b0);
    chk("idle_valid", 32'(data_valid), 32'h0);
    chk("idle_dout",  32'(data_out),   32'h08);

    // Underflow at empty
    step(1'b0, 8'h00, 1'b1);
    chk("unf_flag",  32'(underflow),  32'h1);
    chk("unf_valid", 32'(data_valid), 32'h0);
    chk("unf_dout",  32'(data_out),   32'h08);
    chk("unf_count", 32'(count),      32'h0);

    // Simultaneous write+read at count 4, pointers wrap
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0);
    end
    chk("sim_pre_count", 32'(count), 32'h4);
    exp_sim = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h55, 1'b1);
      chk("sim_valid", 32'(data_valid), 32'h1);
      chk("sim_data",  32'(data_out),   32'(exp_sim[i]));
      chk("sim_count", 32'(count),      32'h4);
    end

    // Async reset mid-stream with count 5, no clock edge
    step(1'b1, 8'h55, 1'b0);
    chk("pre_clr_count", 32'(count), 32'h5);
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
    #2 Clear = 1'b0;
    #1;
    chk_reset_outputs("async_clr");
    Clear = 1'b1;
    step(1'b1, 8'h77, 1'b0);
    chk("post_clr_count", 32'(count), 32'h1);
    step(1'b0, 8'h00, 1'b1);
    chk("post_clr_data",  32'(data_out),   32'h77);
    chk("post_clr_valid", 32'(data_valid), 32'h1);
    chk("post_clr_empty", 32'(empty),      32'h1);

    // Write+read together at FULL: read wins, write rejected
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b0);
    end
    chk("full2_full", 32'(full), 32'h1);
    chk("full2_ovf0", 32'(overflow), 32'h0);
    step(1'b1, 8'hBB, 1'b1);
    chk("wrrd_full_ovf",   32'(overflow),   32'h1);
    chk("wrrd_full_count", 32'(count),      32'h7);
    chk("wrrd_full_data",  32'(data_out),   32'h30);
    chk("wrrd_full_full",  32'(full),       32'h0);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("tail_data", 32'(data_out), 32'(8'h30 + i));
    end
    chk("tail_empty", 32'(empty), 32'h1);

    // Write+read together at EMPTY: write wins, read rejected
    step(1'b1, 8'h66, 1'b1);
    chk("wrrd_empty_unf",   32'(underflow),  32'h1);
    chk("wrrd_empty_valid", 32'(data_valid), 32'h0);
    chk("wrrd_empty_count", 32'(count),      32'h1);
    step(1'b0, 8'h00, 1'b1);
    chk("wrrd_empty_data",  32'(data_out),   32'h66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_store.md
# fifo_store

Storage and control stage of the FSM-based FIFO, directly downstream of the 8-bit write buffer. It accepts the write buffer's registered output on a write request and holds words in a 2^addr_bits-entry circular store. A status FSM (EMPTY/NORMAL/FULL) produces registered read data with a one-cycle valid pulse, plus full/empty/occupancy status and sticky overflow/underflow error flags.

## Interface
- width, 7, MSB index of the data word (word is width+1 bits)
- addr_bits, 3, pointer width; depth DEPTH = 2^addr_bits (addr_bits ≥ 1)
- clk  in  1  rising-edge clock
- Clear  in  1  asynchronous, active-low reset
- wr_req  in  1  write request, sampled on rising clk
- data_in  in  width+1  write data (driven by write buffer data_out)
- rd_req  in  1  read request, sampled on rising clk
- data_out  out  width+1  registered read data
- data_valid  out  1  one-cycle pulse: data_out updated this cycle
- full  out  1  store holds DEPTH words
- empty  out  1  store holds 0 words
- count  out  addr_bits+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Reset (Clear low, any time, async): state EMPTY, wr_ptr=rd_ptr=0, count=0, empty=1, full=0, data_out=0, data_valid=0, overflow=0, underflow=0. Storage array not reset.
- Write accepted iff wr_req=1 and state≠FULL: mem[wr_ptr]<=data_in, wr_ptr increments modulo DEPTH.
- Read accepted iff rd_req=1 and state≠EMPTY: data_out<=mem[rd_ptr], rd_ptr increments modulo DEPTH, data_valid=1 next cycle.
- Rejected write: overflow set, no state/pointer change. Rejected read: underflow set, data_out holds, data_valid=0.
- Flags clear only on Clear.
- FSM, registered state:
  - EMPTY: accepted write → NORMAL; wr+rd together → write accepted, read rejected (underflow), → NORMAL.
  - NORMAL: write only with count=DEPTH-1 → FULL; read only with count=1 → EMPTY; both → both accepted, count unchanged, stay.
  - FULL: read → NORMAL; wr+rd together → read accepted, write rejected (overflow), → NORMAL.
- count: +1 on write-only accepted, −1 on read-only accepted, unchanged on both; never wraps.
- full = (state==FULL), empty = (state==EMPTY), both registered outputs of FSM.

## Timing
- Write latency: word written at edge N is readable by rd_req sampled at edge N+1.
- Read latency: rd_req accepted at edge N → data_out and data_valid valid after edge N, for one cycle; data_out holds until next accepted read.
- Back-to-back reads/writes every cycle supported at full rate.
- Pointer wrap: after DEPTH writes, wr_ptr returns to 0 with no bubble.
- Clear asserted mid-operation: all outputs reach reset values immediately, independent of clk; first accepted request is on first rising edge after Clear deasserts.

## Structure
- Package fifo_pkg: state encoding constants ST_EMPTY, ST_NORMAL, ST_FULL (2-bit), DEPTH derivation from addr_bits.
- Sub-module fifo_ram: (width+1)×DEPTH register array, synchronous write port, synchronous read port; no reset. FSM, pointers, count and flags stay in fifo_store.

## Test plan
- Reset: Clear low with random inputs → data_out=0, count=0, empty=1, full=0, flags=0.
- Fill/drain (addr_bits=3): write 0x01..0x08 → full=1, count=8 after 8th edge; 8 reads → 0x01..0x08 in order, each with one data_valid pulse, empty=1 at end.
- Overflow: at full, wr_req with 0xAA → overflow=1, count stays 8, 0xAA never read back.
- Underflow: at empty, rd_req → underflow=1, data_valid=0, data_out holds previous value.
- Simultaneous: count=4, wr 0x55 + rd same cycle for 10 cycles → count stays 4, reads in order, pointers wrap cleanly; wr+rd at FULL → overflow=1, count 7.
- Async reset mid-stream: Clear pulsed low between edges with count=5 → outputs reset without clock edge; next write reads back correctly.
